// File: rtl/ad7946_pkg.sv
// ---------------------------------------------------------------------------
// ad7946_pkg
// Shared types and helpers for the AD7946 capture sequencer.
//   cap_state_t : capture FSM states
//   BEAT_W      : AXI-Stream beat width (32)
//   LANE_W      : per-channel lane width inside a beat (16)
//   pack_pair   : builds an output beat from two zero-extended samples
// ---------------------------------------------------------------------------
package ad7946_pkg;

    localparam int BEAT_W = 32;
    localparam int LANE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DRAIN
    } cap_state_t;

    // Lanes arrive already zero-extended, so for 14-bit samples this is
    // {2'b0, ch1, 2'b0, ch0}.
    function automatic logic [BEAT_W-1:0] pack_pair(
        input logic [LANE_W-1:0] ch0,
        input logic [LANE_W-1:0] ch1
    );
        return {ch1, ch0};
    endfunction

endpackage

// File: rtl/ad7946_capture_sequencer_if.sv
// ---------------------------------------------------------------------------
// ad7946_capture_sequencer_if
// AXI-Stream output bundle of the capture sequencer.
//   m_tdata  : packed beat            (master -> slave)
//   m_tvalid : beat valid             (master -> slave)
//   m_tlast  : final beat of capture  (master -> slave)
//   m_tready : sink ready             (slave  -> master)
// ---------------------------------------------------------------------------
interface ad7946_capture_sequencer_if;
    import ad7946_pkg::*;

    logic [BEAT_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;

    modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
    modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);

endinterface

// File: rtl/ad7946_stream_reg.sv
// ---------------------------------------------------------------------------
// ad7946_stream_reg
// Single-entry AXI-Stream output register with drop detection.
//   clk, resetn     : clock, synchronous active-low reset
//   flush_i         : discard the pending beat (overflow is kept)
//   load_i          : a new beat is offered this cycle
//   data_i, last_i  : beat payload and last flag
//   clr_ovf_i       : clear the sticky overflow flag
//   axis            : AXI-Stream master side
//   last_accept_o   : the last beat is being accepted this cycle
//   overflow_o      : sticky, a beat was dropped
// ---------------------------------------------------------------------------
module ad7946_stream_reg
    import ad7946_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic [BEAT_W-1:0] data_i,
    input  logic              last_i,
    input  logic              clr_ovf_i,
    ad7946_capture_sequencer_if.master axis,
    output logic              last_accept_o,
    output logic              overflow_o
);

    logic [BEAT_W-1:0] tdata_q;
    logic              tvalid_q;
    logic              tlast_q;
    logic              ovf_q;
    logic              blocked;
    logic              accept;

    assign accept  = tvalid_q & axis.m_tready;
    // A beat that is still waiting cannot be replaced without breaking AXIS.
    assign blocked = tvalid_q & ~axis.m_tready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (flush_i) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            if (clr_ovf_i) begin
                ovf_q <= 1'b0;
            end
            if (load_i) begin
                if (blocked) begin
                    ovf_q <= 1'b1;
                    // Dropped final pair: the waiting beat closes the capture.
                    if (last_i) begin
                        tlast_q <= 1'b1;
                    end
                end else begin
                    tdata_q  <= data_i;
                    tvalid_q <= 1'b1;
                    tlast_q  <= last_i;
                end
            end else if (accept) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end
        end
    end

    assign axis.m_tdata  = tdata_q;
    assign axis.m_tvalid = tvalid_q;
    assign axis.m_tlast  = tlast_q;
    assign last_accept_o = accept & tlast_q;
    assign overflow_o    = ovf_q;

endmodule

// File: rtl/ad7946_capture_sequencer.sv
// ---------------------------------------------------------------------------
// ad7946_capture_sequencer
// Gates the AD7946 controller's interleaved ch0/ch1 sample stream into
// software-armed capture windows of num_pairs pairs, with optional trigger
// and 1-of-(decim+1) decimation, and emits pairs as 32-bit AXIS beats.
//   clk, resetn            : clock, synchronous active-low reset
//   ch0_dv, ch1_dv, din    : sample stream from the ADC controller
//   arm, abort             : one-cycle capture start / cancel requests
//   trig_mode, trig        : 0 = start on arm, 1 = wait for trig level
//   num_pairs, decim       : capture length and decimation
//   axis                   : AXI-Stream master output
//   busy, done             : status / completion pulse
//   overflow, cfg_err      : sticky error flags
// ---------------------------------------------------------------------------
module ad7946_capture_sequencer
    import ad7946_pkg::*;
#(
    parameter int DATA_W  = 14,
    parameter int COUNT_W = 16,
    parameter int DECIM_W = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               ch0_dv,
    input  logic               ch1_dv,
    input  logic [DATA_W-1:0]  din,
    input  logic               arm,
    input  logic               abort,
    input  logic               trig_mode,
    input  logic               trig,
    input  logic [COUNT_W-1:0] num_pairs,
    input  logic [DECIM_W-1:0] decim,
    ad7946_capture_sequencer_if.master axis,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic               cfg_err
);

    cap_state_t         state_q, state_d;
    logic               done_q, done_d;
    logic [COUNT_W-1:0] num_pairs_q;
    logic [DECIM_W-1:0] decim_q;
    logic               trig_mode_q;
    logic               cfg_err_q;
    logic [DATA_W-1:0]  ch0_hold_q;
    logic               ch0_valid_q;
    logic [DECIM_W-1:0] decim_cnt_q;
    logic [COUNT_W-1:0] pair_cnt_q;

    logic               arm_ok;
    logic               pair_done;
    logic               keep;
    logic               last_pair;
    logic               last_accept;
    logic [BEAT_W-1:0]  beat;

    assign arm_ok    = (state_q == ST_IDLE) & arm & ~abort;
    // ch1 only completes a pair when a ch0 sample is held; stray ch1 is ignored.
    assign pair_done = (state_q == ST_CAPTURE) & ch1_dv & ~ch0_dv & ch0_valid_q;
    assign keep      = pair_done & (decim_cnt_q == '0);
    assign last_pair = (pair_cnt_q + COUNT_W'(1)) == num_pairs_q;
    assign beat      = pack_pair(LANE_W'(ch0_hold_q), LANE_W'(din));

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm && (num_pairs != '0)) begin
                        state_d = trig_mode ? ST_ARMED : ST_CAPTURE;
                    end
                end
                ST_ARMED: begin
                    if (trig || !trig_mode_q) begin
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (keep && last_pair) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (last_accept) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            done_q      <= 1'b0;
            num_pairs_q <= '0;
            decim_q     <= '0;
            trig_mode_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            ch0_hold_q  <= '0;
            ch0_valid_q <= 1'b0;
            decim_cnt_q <= '0;
            pair_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (arm_ok) begin
                num_pairs_q <= num_pairs;
                decim_q     <= decim;
                trig_mode_q <= trig_mode;
                cfg_err_q   <= (num_pairs == '0);
                ch0_valid_q <= 1'b0;
                decim_cnt_q <= '0;
                pair_cnt_q  <= '0;
            end
            if ((state_q == ST_CAPTURE) && !abort) begin
                if (ch0_dv) begin
                    // A repeated ch0 simply replaces the held sample.
                    ch0_hold_q  <= din;
                    ch0_valid_q <= 1'b1;
                end else if (pair_done) begin
                    ch0_valid_q <= 1'b0;
                    decim_cnt_q <= (decim_cnt_q == decim_q) ? '0 : decim_cnt_q + DECIM_W'(1);
                    if (keep) begin
                        pair_cnt_q <= pair_cnt_q + COUNT_W'(1);
                    end
                end
            end
        end
    end

    ad7946_stream_reg u_stream_reg (
        .clk           (clk),
        .resetn        (resetn),
        .flush_i       (abort),
        .load_i        (keep),
        .data_i        (beat),
        .last_i        (last_pair),
        .clr_ovf_i     (arm_ok),
        .axis          (axis),
        .last_accept_o (last_accept),
        .overflow_o    (overflow)
    );

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_ad7946_capture_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ad7946_capture_sequencer
// Directed bench for the AD7946 capture sequencer: immediate capture,
// trigger + decimation, back-pressure, ch0 alignment, abort and
// config-error / reset behaviour.
// ---------------------------------------------------------------------------
module tb_ad7946_capture_sequencer;
    import ad7946_pkg::*;

    logic        clk       = 1'b0;
    logic        resetn    = 1'b0;
    logic        ch0_dv    = 1'b0;
    logic        ch1_dv    = 1'b0;
    logic [13:0] din       = '0;
    logic        arm       = 1'b0;
    logic        abort     = 1'b0;
    logic        trig_mode = 1'b0;
    logic        trig      = 1'b0;
    logic [15:0] num_pairs = '0;
    logic [7:0]  decim     = '0;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        cfg_err;

    ad7946_capture_sequencer_if axis_if ();

    always #5 clk = ~clk;

    ad7946_capture_sequencer #(
        .DATA_W  (14),
        .COUNT_W (16),
        .DECIM_W (8)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .ch0_dv    (ch0_dv),
        .ch1_dv    (ch1_dv),
        .din       (din),
        .arm       (arm),
        .abort     (abort),
        .trig_mode (trig_mode),
        .trig      (trig),
        .num_pairs (num_pairs),
        .decim     (decim),
        .axis      (axis_if),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .cfg_err   (cfg_err)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    logic [31:0] beat_q[$];
    logic        last_q[$];

    // Beats are recorded on the falling edge preceding the accepting edge.
    always @(negedge clk) begin
        if (resetn) begin
            if (axis_if.m_tvalid && axis_if.m_tready) begin
                beat_q.push_back(axis_if.m_tdata);
                last_q.push_back(axis_if.m_tlast);
            end
            if (done) begin
                done_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_ch0(input logic [13:0] v);
        din = v; ch0_dv = 1'b1;
        tick(1);
        ch0_dv = 1'b0;
        tick(3);
    endtask

    task automatic send_ch1(input logic [13:0] v);
        din = v; ch1_dv = 1'b1;
        tick(1);
        ch1_dv = 1'b0;
        tick(3);
    endtask

    task automatic send_pair(input logic [13:0] a, input logic [13:0] b);
        send_ch0(a);
        send_ch1(b);
        tick(6);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target);
        for (int i = 0; i < 400 && done_cnt < target; i++) begin
            tick(1);
        end
        check(tag, done_cnt, target);
    endtask

    task automatic expect_beat(input string tag, input logic [31:0] d, input logic l);
        logic [31:0] got_d;
        logic        got_l;
        got_d = (beat_q.size() > 0) ? beat_q.pop_front() : 32'hFFFF_FFFF;
        got_l = (last_q.size() > 0) ? last_q.pop_front() : 1'bx;
        check({tag, "_data"}, got_d, d);
        check({tag, "_last"}, {31'd0, got_l}, {31'd0, l});
    endtask

    initial begin
        axis_if.m_tready = 1'b1;

        // Reset state
        tick(3);
        check("rst_tvalid", {31'd0, axis_if.m_tvalid}, 32'd0);
        check("rst_tlast", {31'd0, axis_if.m_tlast}, 32'd0);
        check("rst_tdata", axis_if.m_tdata, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_flags", {30'd0, overflow, cfg_err}, 32'd0);
        resetn = 1'b1;
        tick(2);

        // Immediate capture, 4 pairs
        trig_mode = 1'b0; num_pairs = 16'd4; decim = 8'd0;
        pulse_arm();
        check("t1_busy", {31'd0, busy}, 32'd1);
        repeat (4) send_pair(14'h0123, 14'h1ABC);
        wait_done("t1_done", 1);
        check("t1_nbeats", beat_q.size(), 32'd4);
        for (int k = 0; k < 4; k++) begin
            expect_beat($sformatf("t1_b%0d", k), 32'h1ABC_0123, (k == 3));
        end
        check("t1_busy_after", {31'd0, busy}, 32'd0);
        check("t1_ovf", {31'd0, overflow}, 32'd0);

        // Trigger + decimation: keep pairs 0, 3, 6 after trigger
        beat_q.delete(); last_q.delete();
        trig_mode = 1'b1; num_pairs = 16'd3; decim = 8'd2;
        trig = 1'b1; arm = 1'b1;
        tick(1);
        arm = 1'b0; trig = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send_pair(14'h0100 + 14'(k), 14'h0200 + 14'(k));
        end
        check("t2_busy_armed", {31'd0, busy}, 32'd1);
        check("t2_no_early", beat_q.size(), 32'd0);
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
        tick(1);
        for (int k = 0; k < 7; k++) begin
            send_pair(14'h0300 + 14'(k), 14'h0400 + 14'(k));
        end
        wait_done("t2_done", 2);
        check("t2_nbeats", beat_q.size(), 32'd3);
        expect_beat("t2_b0", 32'h0400_0300, 1'b0);
        expect_beat("t2_b1", 32'h0403_0303, 1'b0);
        expect_beat("t2_b2", 32'h0406_0306, 1'b1);

        // Back-pressure: pair 2 dropped, counts toward num_pairs
        beat_q.delete(); last_q.delete();
        trig_mode = 1'b0; num_pairs = 16'd3; decim = 8'd0;
        axis_if.m_tready = 1'b0;
        pulse_arm();
        send_pair(14'h0011, 14'h0022);
        check("t3_tvalid", {31'd0, axis_if.m_tvalid}, 32'd1);
        check("t3_hold1", axis_if.m_tdata, 32'h0022_0011);
        send_pair(14'h0033, 14'h0044);
        check("t3_hold2", axis_if.m_tdata, 32'h0022_0011);
        check("t3_ovf", {31'd0, overflow}, 32'd1);
        check("t3_nolast", {31'd0, axis_if.m_tlast}, 32'd0);
        axis_if.m_tready = 1'b1;
        tick(2);
        send_pair(14'h0055, 14'h0066);
        wait_done("t3_done", 3);
        check("t3_nbeats", beat_q.size(), 32'd2);
        expect_beat("t3_b0", 32'h0022_0011, 1'b0);
        expect_beat("t3_b1", 32'h0066_0055, 1'b1);
        check("t3_ovf_sticky", {31'd0, overflow}, 32'd1);

        // Alignment: stray ch1 ignored, second ch0 overwrites the first
        beat_q.delete(); last_q.delete();
        num_pairs = 16'd1;
        pulse_arm();
        check("t4_ovf_cleared", {31'd0, overflow}, 32'd0);
        send_ch1(14'h0777);
        send_ch0(14'h0AAA);
        send_ch0(14'h0101);
        send_ch1(14'h0202);
        wait_done("t4_done", 4);
        check("t4_nbeats", beat_q.size(), 32'd1);
        expect_beat("t4_b0", 32'h0202_0101, 1'b1);

        // Abort with pending beat and simultaneous arm
        beat_q.delete(); last_q.delete();
        num_pairs = 16'd3;
        axis_if.m_tready = 1'b0;
        pulse_arm();
        send_pair(14'h0010, 14'h0020);
        send_pair(14'h0030, 14'h0040);
        check("t5_pending", {31'd0, axis_if.m_tvalid}, 32'd1);
        abort = 1'b1; arm = 1'b1;
        tick(1);
        abort = 1'b0; arm = 1'b0;
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_tvalid", {31'd0, axis_if.m_tvalid}, 32'd0);
        check("t5_tlast", {31'd0, axis_if.m_tlast}, 32'd0);
        check("t5_ovf_kept", {31'd0, overflow}, 32'd1);
        axis_if.m_tready = 1'b1;
        tick(5);
        check("t5_arm_ignored", {31'd0, busy}, 32'd0);
        check("t5_nbeats", beat_q.size(), 32'd0);
        check("t5_no_done", done_cnt, 32'd4);

        // Config error
        num_pairs = 16'd0;
        pulse_arm();
        check("t6_cfg_err", {31'd0, cfg_err}, 32'd1);
        check("t6_ovf_cleared", {31'd0, overflow}, 32'd0);
        tick(3);
        check("t6_busy", {31'd0, busy}, 32'd0);

        // Reset mid-capture
        num_pairs = 16'd3;
        axis_if.m_tready = 1'b0;
        pulse_arm();
        check("t7_cfg_err_clr", {31'd0, cfg_err}, 32'd0);
        send_pair(14'h0005, 14'h0006);
        send_pair(14'h0007, 14'h0008);
        check("t7_ovf_pre", {31'd0, overflow}, 32'd1);
        resetn = 1'b0;
        tick(1);
        check("t7_tvalid", {31'd0, axis_if.m_tvalid}, 32'd0);
        check("t7_tlast", {31'd0, axis_if.m_tlast}, 32'd0);
        check("t7_tdata", axis_if.m_tdata, 32'd0);
        check("t7_busy", {31'd0, busy}, 32'd0);
        check("t7_flags", {29'd0, done, overflow, cfg_err}, 32'd0);
        resetn = 1'b1;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
